// File: rtl/rmii_pkg.sv
// Shared types and constants for the RMII transmit path.
package rmii_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } tx_state_t;

    // Payload byte held while its four dibits are on the wire.
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } tx_beat_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    localparam int unsigned DIBITS_PER_BYTE = 4;
    localparam int unsigned FCS_DIBITS      = 16;

endpackage

// File: rtl/rmii_tx_crc32_d8.sv
// Combinational reflected CRC-32 advance by one byte, LSB first.
// Also intended for the receive-side FCS checker.
module crc32_d8
    import rmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // Eight bit-serial shift steps unrolled into one cycle.
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/rmii_tx.sv
// RMII 100 Mbit/s transmitter: byte stream in, preamble/SFD/payload/FCS/IFG
// out as dibits, one per eth_clk.
// Optional macro RMII_TX_PAD_EN: pad short payloads with 0x00 up to MIN_PAYLOAD.
module rmii_tx
    import rmii_pkg::*;
#(
    parameter int unsigned PREAMBLE_BYTES = 7,
    parameter int unsigned IFG_BYTES      = 12
`ifdef RMII_TX_PAD_EN
    ,
    parameter int unsigned MIN_PAYLOAD    = 60
`endif
) (
    input  logic       eth_clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       eth_txen,
    output logic [1:0] eth_tx,
    output logic       busy,
    output logic       underrun
);

    localparam int unsigned PRE_CLKS = DIBITS_PER_BYTE * PREAMBLE_BYTES;
    localparam int unsigned IFG_CLKS = DIBITS_PER_BYTE * IFG_BYTES;
    localparam int unsigned CNT_MAX0 = (PRE_CLKS > IFG_CLKS) ? PRE_CLKS : IFG_CLKS;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > FCS_DIBITS) ? CNT_MAX0 : FCS_DIBITS;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX);

    tx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    tx_beat_t         beat, beat_n;
    logic [31:0]      crc, crc_n, crc_upd, fcs_n;
    logic [7:0]       crc_din;
    logic             txen_n, busy_n, underrun_n;
    logic [1:0]       tx_n;
    logic             last_dibit;

`ifdef RMII_TX_PAD_EN
    localparam int unsigned PAY_W = $clog2(MIN_PAYLOAD + 1);
    logic [PAY_W-1:0] pay, pay_n;
    logic             short_frame;
    assign short_frame = (pay < PAY_W'(MIN_PAYLOAD));
`endif

    // Byte request: last SFD dibit and last dibit of every non-final payload byte.
    assign last_dibit = (cnt == CNT_W'(DIBITS_PER_BYTE - 1));
    assign tx_ready   = last_dibit && ((state == SFD) || ((state == DATA) && !beat.last));

    // Accepted bytes feed the CRC; pad bytes (after the final byte) feed zeros.
    assign crc_din = ((state == SFD) || ((state == DATA) && !beat.last)) ? tx_data : 8'h00;

    crc32_d8 u_crc (
        .crc_in (crc),
        .data   (crc_din),
        .crc_out(crc_upd)
    );

    // Next-state logic; wire outputs are derived from the next state so they
    // change on the same edge as the state.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CNT_W'(1);
        beat_n     = beat;
        crc_n      = crc;
        underrun_n = 1'b0;
`ifdef RMII_TX_PAD_EN
        pay_n      = pay;
`endif

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (tx_valid) begin
                    state_n = PREAMBLE;
                    crc_n   = CRC_INIT;
`ifdef RMII_TX_PAD_EN
                    pay_n   = '0;
`endif
                end
            end

            PREAMBLE: begin
                if (cnt == CNT_W'(PRE_CLKS - 1)) begin
                    state_n = SFD;
                    cnt_n   = '0;
                end
            end

            SFD: begin
                if (last_dibit) begin
                    cnt_n = '0;
                    if (tx_valid) begin
                        state_n = DATA;
                        beat_n  = '{last: tx_last, data: tx_data};
                        crc_n   = crc_upd;
`ifdef RMII_TX_PAD_EN
                        if (short_frame) pay_n = pay + PAY_W'(1);
`endif
                    end else begin
                        state_n    = IFG;
                        underrun_n = 1'b1;
                        crc_n      = CRC_INIT;
                    end
                end
            end

            DATA: begin
                if (last_dibit) begin
                    cnt_n = '0;
                    if (beat.last) begin
`ifdef RMII_TX_PAD_EN
                        if (short_frame) begin
                            state_n = PAD;
                            crc_n   = crc_upd;
                            pay_n   = pay + PAY_W'(1);
                        end else begin
                            state_n = FCS;
                        end
`else
                        state_n = FCS;
`endif
                    end else if (tx_valid) begin
                        beat_n = '{last: tx_last, data: tx_data};
                        crc_n  = crc_upd;
`ifdef RMII_TX_PAD_EN
                        if (short_frame) pay_n = pay + PAY_W'(1);
`endif
                    end else begin
                        state_n    = IFG;
                        underrun_n = 1'b1;
                        crc_n      = CRC_INIT;
                    end
                end
            end

            PAD: begin
`ifdef RMII_TX_PAD_EN
                if (last_dibit) begin
                    cnt_n = '0;
                    if (short_frame) begin
                        crc_n = crc_upd;
                        pay_n = pay + PAY_W'(1);
                    end else begin
                        state_n = FCS;
                    end
                end
`else
                // Unreachable without padding; fall back to the gap.
                state_n = IFG;
                cnt_n   = '0;
`endif
            end

            FCS: begin
                if (cnt == CNT_W'(FCS_DIBITS - 1)) begin
                    state_n = IFG;
                    cnt_n   = '0;
                end
            end

            IFG: begin
                if (cnt == CNT_W'(IFG_CLKS - 1)) begin
                    cnt_n = '0;
                    // Pending frame starts straight out of the gap.
                    if (tx_valid) begin
                        state_n = PREAMBLE;
                        crc_n   = CRC_INIT;
`ifdef RMII_TX_PAD_EN
                        pay_n   = '0;
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Wire values for the state being entered.
        fcs_n  = ~crc_n;
        txen_n = 1'b0;
        tx_n   = 2'b00;
        busy_n = (state_n != IDLE);
        case (state_n)
            PREAMBLE: begin
                txen_n = 1'b1;
                tx_n   = PREAMBLE_BYTE[1:0];
            end
            SFD: begin
                txen_n = 1'b1;
                tx_n   = SFD_BYTE[{cnt_n[1:0], 1'b0} +: 2];
            end
            DATA: begin
                txen_n = 1'b1;
                tx_n   = beat_n.data[{cnt_n[1:0], 1'b0} +: 2];
            end
            PAD: begin
                txen_n = 1'b1;
                tx_n   = 2'b00;
            end
            FCS: begin
                txen_n = 1'b1;
                tx_n   = fcs_n[{cnt_n[3:0], 1'b0} +: 2];
            end
            default: begin
                txen_n = 1'b0;
                tx_n   = 2'b00;
            end
        endcase
    end

    // State, datapath and registered wire outputs.
    always_ff @(posedge eth_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            beat     <= '0;
            crc      <= CRC_INIT;
            eth_txen <= 1'b0;
            eth_tx   <= 2'b00;
            busy     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            beat     <= beat_n;
            crc      <= crc_n;
            eth_txen <= txen_n;
            eth_tx   <= tx_n;
            busy     <= busy_n;
            underrun <= underrun_n;
        end
    end

`ifdef RMII_TX_PAD_EN
    // Payload length tracker for padding.
    always_ff @(posedge eth_clk or posedge rst) begin
        if (rst) begin
            pay <= '0;
        end else begin
            pay <= pay_n;
        end
    end
`endif

endmodule

// File: tb/tb_rmii_tx.sv
// Self-checking bench for rmii_tx: random payloads against a frame-level
// reference model of the wire sequence. Honours RMII_TX_PAD_EN.
module tb_rmii_tx;

    localparam int PRE_CLKS    = 28;
    localparam int IFG_CLKS    = 48;
    localparam int MIN_PAYLOAD = 60;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef logic [7:0] bytes_t[$];
    typedef logic [5:0] trace_t[$];   // {txen, tx[1:0], busy, underrun, ready}
    typedef int         ints_t[$];

    logic       eth_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, eth_txen, busy, underrun;
    logic [1:0] eth_tx;

    int checks = 0;
    int failures = 0;

    always #10 eth_clk = ~eth_clk;

    rmii_tx dut (
        .eth_clk (eth_clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_last (tx_last),
        .tx_ready(tx_ready),
        .eth_txen(eth_txen),
        .eth_tx  (eth_tx),
        .busy    (busy),
        .underrun(underrun)
    );

    function automatic logic [31:0] crc_bytes(input logic [31:0] init, input bytes_t b);
        logic [31:0] c;
        logic fb;
        c = init;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    function automatic int padded(input int n);
`ifdef RMII_TX_PAD_EN
        return (n < MIN_PAYLOAD) ? MIN_PAYLOAD : n;
`else
        return n;
`endif
    endfunction

    // Expected per-cycle wire trace: one idle sample, each frame, gaps, final idle sample.
    function automatic void build_expected(input bytes_t data, input ints_t lens,
                                           input int drop_at, output trace_t e);
        int pos;
        pos = 0;
        e = {};
        e.push_back(6'b0);
        foreach (lens[f]) begin
            bytes_t body;
            int nshow;
            bit aborted;
            logic [31:0] fcs;
            aborted = (f == lens.size() - 1) && (drop_at >= 0) && (drop_at < lens[f]);
            nshow = aborted ? drop_at : lens[f];
            body = {};
            for (int i = 0; i < nshow; i++) body.push_back(data[pos + i]);
            if (!aborted) while (body.size() < padded(lens[f])) body.push_back(8'h00);
            repeat (PRE_CLKS) e.push_back({1'b1, 2'b01, 1'b1, 1'b0, 1'b0});
            for (int k = 0; k < 4; k++)
                e.push_back({1'b1, (k == 3) ? 2'b11 : 2'b01, 1'b1, 1'b0, 1'(k == 3)});
            foreach (body[i])
                for (int k = 0; k < 4; k++)
                    e.push_back({1'b1, body[i][2*k +: 2], 1'b1, 1'b0,
                                 1'((k == 3) && (i < lens[f] - 1))});
            if (!aborted) begin
                fcs = ~crc_bytes(32'hFFFFFFFF, body);
                for (int j = 0; j < 16; j++) e.push_back({1'b1, fcs[2*j +: 2], 1'b1, 1'b0, 1'b0});
            end
            for (int j = 0; j < IFG_CLKS; j++)
                e.push_back({1'b0, 2'b00, 1'b1, 1'(aborted && j == 0), 1'b0});
            pos += lens[f];
        end
        e.push_back(6'b0);
    endfunction

    function automatic string trace_diff(input trace_t got, input trace_t exp);
        int n;
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++)
            if (got[i] !== exp[i])
                return $sformatf("cycle %0d got %b required %b", i, got[i], exp[i]);
        if (got.size() != exp.size())
            return $sformatf("length got %0d required %0d", got.size(), exp.size());
        return "";
    endfunction

    function automatic void frame_bytes(input trace_t t, output bytes_t b);
        int s, e;
        s = -1;
        b = {};
        foreach (t[i]) if (t[i][5] && s < 0) s = i;
        if (s < 0) return;
        e = s;
        while (e < t.size() && t[e][5]) e++;
        for (int i = s + PRE_CLKS + 4; i + 3 < e; i += 4)
            b.push_back({t[i+3][4:3], t[i+2][4:3], t[i+1][4:3], t[i][4:3]});
    endfunction

    function automatic int txen_count(input trace_t t);
        int n;
        n = 0;
        foreach (t[i]) if (t[i][5]) n++;
        return n;
    endfunction

    task automatic present(input bytes_t data, input bit lastf[$], input int idx, input int stop);
        if (idx < stop) begin
            tx_valid = 1'b1;
            tx_data  = data[idx];
            tx_last  = lastf[idx];
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            tx_last  = 1'($urandom);
        end
    endtask

    // Drive frames back to back and record the wire until busy falls.
    task automatic run_traffic(input bytes_t data, input ints_t lens, input int drop_at,
                               output trace_t obs);
        bit lastf[$];
        int stop, idx, cyc;
        bit seen, take;
        stop = 0;
        foreach (lens[f]) begin
            for (int i = 0; i < lens[f]; i++) lastf.push_back(i == lens[f] - 1);
            stop += lens[f];
        end
        if (drop_at >= 0 && drop_at < lens[lens.size()-1]) stop = stop - lens[lens.size()-1] + drop_at;
        @(posedge eth_clk);
        #1;
        idx = 0;
        present(data, lastf, idx, stop);
        obs = {};
        seen = 0;
        cyc = 0;
        forever begin
            @(negedge eth_clk);
            obs.push_back({eth_txen, eth_tx, busy, underrun, tx_ready});
            take = tx_ready && tx_valid;
            if (busy) seen = 1;
            else if (seen) break;
            cyc++;
            if (cyc > 5000) break;
            @(posedge eth_clk);
            #1;
            if (take) begin
                idx++;
                present(data, lastf, idx, stop);
            end
        end
        tx_valid = 1'b0;
    endtask

    function automatic void rand_bytes(input int n, output bytes_t b);
        b = {};
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    endfunction

    task automatic test_reset();
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
        repeat (3) @(negedge eth_clk);
        checks++; if (eth_txen !== 1'b0) begin failures++; $display("FAIL reset_txen: got %b required 0", eth_txen); end
        checks++; if (eth_tx !== 2'b00) begin failures++; $display("FAIL reset_tx: got %b required 00", eth_tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %b required 0", underrun); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b required 0", tx_ready); end
        tx_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge eth_clk);
    endtask

    task automatic test_known_frame();
        bytes_t d, fb;
        trace_t obs, exp;
        string msg;
        logic [31:0] fcs;
        d = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        build_expected(d, '{9}, -1, exp);
        run_traffic(d, '{9}, -1, obs);
        msg = trace_diff(obs, exp);
        checks++; if (msg != "") begin failures++; $display("FAIL known_trace: %s", msg); end
        checks++;
        if (txen_count(obs) != PRE_CLKS + 4 + 4 * padded(9) + 16) begin
            failures++;
            $display("FAIL known_txen_len: got %0d required %0d", txen_count(obs), PRE_CLKS + 4 + 4 * padded(9) + 16);
        end
        frame_bytes(obs, fb);
        checks++;
        if (crc_bytes(32'hFFFFFFFF, fb) !== RESIDUE) begin
            failures++;
            $display("FAIL known_residue: got %h required %h", crc_bytes(32'hFFFFFFFF, fb), RESIDUE);
        end
`ifndef RMII_TX_PAD_EN
        fcs = (fb.size() >= 4) ? {fb[fb.size()-1], fb[fb.size()-2], fb[fb.size()-3], fb[fb.size()-4]} : 32'h0;
        checks++;
        if (fcs !== 32'hCBF43926) begin
            failures++;
            $display("FAIL known_fcs: got %h required cbf43926", fcs);
        end
`endif
    endtask

    task automatic test_random_frames();
        bytes_t d, fb;
        trace_t obs, exp;
        string msg;
        int n;
        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(2, 24));
            rand_bytes(n, d);
            build_expected(d, '{n}, -1, exp);
            run_traffic(d, '{n}, -1, obs);
            msg = trace_diff(obs, exp);
            checks++; if (msg != "") begin failures++; $display("FAIL random_trace[%0d] len %0d: %s", it, n, msg); end
            frame_bytes(obs, fb);
            checks++;
            if (crc_bytes(32'hFFFFFFFF, fb) !== RESIDUE) begin
                failures++;
                $display("FAIL random_residue[%0d]: got %h required %h", it, crc_bytes(32'hFFFFFFFF, fb), RESIDUE);
            end
        end
    endtask

    task automatic test_one_byte();
        bytes_t d;
        trace_t obs, exp;
        string msg;
        rand_bytes(1, d);
        build_expected(d, '{1}, -1, exp);
        run_traffic(d, '{1}, -1, obs);
        msg = trace_diff(obs, exp);
        checks++; if (msg != "") begin failures++; $display("FAIL one_byte_trace: %s", msg); end
        checks++;
        if (txen_count(obs) != PRE_CLKS + 4 + 4 * padded(1) + 16) begin
            failures++;
            $display("FAIL one_byte_txen_len: got %0d required %0d", txen_count(obs), PRE_CLKS + 4 + 4 * padded(1) + 16);
        end
    endtask

    task automatic test_back_to_back();
        bytes_t d;
        trace_t obs, exp;
        string msg;
        int e1, s2;
        rand_bytes(13, d);
        build_expected(d, '{5, 8}, -1, exp);
        run_traffic(d, '{5, 8}, -1, obs);
        msg = trace_diff(obs, exp);
        checks++; if (msg != "") begin failures++; $display("FAIL b2b_trace: %s", msg); end
        e1 = -1;
        s2 = -1;
        for (int i = 1; i < obs.size(); i++) begin
            if (e1 < 0 && obs[i-1][5] && !obs[i][5]) e1 = i;
            else if (e1 >= 0 && s2 < 0 && !obs[i-1][5] && obs[i][5]) s2 = i;
        end
        checks++;
        if (e1 < 0 || s2 < 0 || (s2 - e1) != IFG_CLKS) begin
            failures++;
            $display("FAIL b2b_gap: got %0d required %0d", s2 - e1, IFG_CLKS);
        end
    endtask

    task automatic test_underrun();
        bytes_t d;
        trace_t obs, exp;
        string msg;
        int pulses;
        rand_bytes(10, d);
        build_expected(d, '{10}, 3, exp);
        run_traffic(d, '{10}, 3, obs);
        msg = trace_diff(obs, exp);
        checks++; if (msg != "") begin failures++; $display("FAIL underrun_trace: %s", msg); end
        pulses = 0;
        foreach (obs[i]) if (obs[i][1]) pulses++;
        checks++; if (pulses != 1) begin failures++; $display("FAIL underrun_pulses: got %0d required 1", pulses); end
        checks++;
        if (txen_count(obs) != PRE_CLKS + 4 + 12) begin
            failures++;
            $display("FAIL underrun_txen_len: got %0d required %0d", txen_count(obs), PRE_CLKS + 4 + 12);
        end
    endtask

    task automatic test_async_reset();
        bytes_t d, fb;
        trace_t obs, exp;
        string msg;
        @(posedge eth_clk);
        #1;
        tx_valid = 1'b1;
        tx_last  = 1'b0;
        tx_data  = 8'($urandom);
        repeat (38) @(negedge eth_clk);
        checks++; if (eth_txen !== 1'b1) begin failures++; $display("FAIL async_pre_txen: got %b required 1", eth_txen); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (eth_txen !== 1'b0) begin failures++; $display("FAIL async_txen: got %b required 0", eth_txen); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_busy: got %b required 0", busy); end
        tx_valid = 1'b0;
        repeat (2) @(negedge eth_clk);
        rst = 1'b0;
        @(negedge eth_clk);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL async_ready: got %b required 0", tx_ready); end
        rand_bytes(6, d);
        build_expected(d, '{6}, -1, exp);
        run_traffic(d, '{6}, -1, obs);
        msg = trace_diff(obs, exp);
        checks++; if (msg != "") begin failures++; $display("FAIL async_after_trace: %s", msg); end
        frame_bytes(obs, fb);
        checks++;
        if (crc_bytes(32'hFFFFFFFF, fb) !== RESIDUE) begin
            failures++;
            $display("FAIL async_after_residue: got %h required %h", crc_bytes(32'hFFFFFFFF, fb), RESIDUE);
        end
    endtask

    task automatic test_pad();
        bytes_t d, fb;
        trace_t obs, exp;
        string msg;
        rand_bytes(10, d);
        build_expected(d, '{10}, -1, exp);
        run_traffic(d, '{10}, -1, obs);
        msg = trace_diff(obs, exp);
        checks++; if (msg != "") begin failures++; $display("FAIL pad_trace: %s", msg); end
        checks++;
        if (txen_count(obs) != PRE_CLKS + 4 + 4 * padded(10) + 16) begin
            failures++;
            $display("FAIL pad_txen_len: got %0d required %0d", txen_count(obs), PRE_CLKS + 4 + 4 * padded(10) + 16);
        end
        frame_bytes(obs, fb);
        checks++;
        if (crc_bytes(32'hFFFFFFFF, fb) !== RESIDUE) begin
            failures++;
            $display("FAIL pad_residue: got %h required %h", crc_bytes(32'hFFFFFFFF, fb), RESIDUE);
        end
    endtask

    initial begin
        test_reset();
        test_known_frame();
        test_random_frames();
        test_one_byte();
        test_back_to_back();
        test_underrun();
        test_async_reset();
        test_pad();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
